// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver slice.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT0  = 8'hE0;
  localparam logic [7:0] PS2_EXT1  = 8'hE1;

  localparam int PS2_TIMEOUT_DEFAULT = 5000;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a saturating glitch filter for one PS/2 pin.
// The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock50,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the current level; flip on saturation.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and filter registers; idle PS/2 lines sit high.
  always_ff @(posedge clock50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ps2_xlat_rom.sv
// Scan-code set 2 to set 1 lookup for codes below 0x80; unmapped codes return 0x00.
module ps2_xlat_rom (
  input  logic [6:0] code_i,
  output logic [7:0] code_o
);

  // Combinational table so the translated byte is ready in the stop-bit cycle.
  always_comb begin
    code_o = 8'h00;
    unique case (code_i)
      7'h01: code_o = 8'h43;  7'h03: code_o = 8'h3F;  7'h04: code_o = 8'h3D;  7'h05: code_o = 8'h3B;
      7'h06: code_o = 8'h3C;  7'h07: code_o = 8'h58;  7'h09: code_o = 8'h44;  7'h0A: code_o = 8'h42;
      7'h0B: code_o = 8'h40;  7'h0C: code_o = 8'h3E;  7'h0D: code_o = 8'h0F;  7'h0E: code_o = 8'h29;
      7'h11: code_o = 8'h38;  7'h12: code_o = 8'h2A;  7'h14: code_o = 8'h1D;  7'h15: code_o = 8'h10;
      7'h16: code_o = 8'h02;  7'h1A: code_o = 8'h2C;  7'h1B: code_o = 8'h1F;  7'h1C: code_o = 8'h1E;
      7'h1D: code_o = 8'h11;  7'h1E: code_o = 8'h03;  7'h21: code_o = 8'h2E;  7'h22: code_o = 8'h2D;
      7'h23: code_o = 8'h20;  7'h24: code_o = 8'h12;  7'h25: code_o = 8'h05;  7'h26: code_o = 8'h04;
      7'h29: code_o = 8'h39;  7'h2A: code_o = 8'h2F;  7'h2B: code_o = 8'h21;  7'h2C: code_o = 8'h14;
      7'h2D: code_o = 8'h13;  7'h2E: code_o = 8'h06;  7'h31: code_o = 8'h31;  7'h32: code_o = 8'h30;
      7'h33: code_o = 8'h23;  7'h34: code_o = 8'h22;  7'h35: code_o = 8'h15;  7'h36: code_o = 8'h07;
      7'h3A: code_o = 8'h32;  7'h3B: code_o = 8'h24;  7'h3C: code_o = 8'h16;  7'h3D: code_o = 8'h08;
      7'h3E: code_o = 8'h09;  7'h41: code_o = 8'h33;  7'h42: code_o = 8'h25;  7'h43: code_o = 8'h17;
      7'h44: code_o = 8'h18;  7'h45: code_o = 8'h0B;  7'h46: code_o = 8'h0A;  7'h49: code_o = 8'h34;
      7'h4A: code_o = 8'h35;  7'h4B: code_o = 8'h26;  7'h4C: code_o = 8'h27;  7'h4D: code_o = 8'h19;
      7'h4E: code_o = 8'h0C;  7'h52: code_o = 8'h28;  7'h54: code_o = 8'h1A;  7'h55: code_o = 8'h0D;
      7'h58: code_o = 8'h3A;  7'h59: code_o = 8'h36;  7'h5A: code_o = 8'h1C;  7'h5B: code_o = 8'h1B;
      7'h5D: code_o = 8'h2B;  7'h66: code_o = 8'h0E;  7'h69: code_o = 8'h4F;  7'h6B: code_o = 8'h4B;
      7'h6C: code_o = 8'h47;  7'h70: code_o = 8'h52;  7'h71: code_o = 8'h53;  7'h72: code_o = 8'h50;
      7'h73: code_o = 8'h4C;  7'h74: code_o = 8'h4D;  7'h75: code_o = 8'h48;  7'h76: code_o = 8'h01;
      7'h77: code_o = 8'h45;  7'h78: code_o = 8'h57;  7'h79: code_o = 8'h4E;  7'h7A: code_o = 8'h51;
      7'h7B: code_o = 8'h4A;  7'h7C: code_o = 8'h37;  7'h7D: code_o = 8'h49;  7'h7E: code_o = 8'h46;
      default: code_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: conditions the pins, deframes bytes and optionally
// translates set 2 scan codes to set 1 with the F0 break prefix folded into bit 7.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT,
  parameter int TRANSLATE      = 1
) (
  input  logic       clock50,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_data_clk,
  output logic       ps2_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             clkLevel, datLevel, clkPrev_q, fall, accept;
  logic [7:0]       romOut;
  ps2_state_e       state_q, state_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d, data_q, data_d;
  logic             parity_q, parity_d, brk_q, brk_d;
  logic             stb_q, stb_d, err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilter (
    .clock50 (clock50),
    .rst_n   (rst_n),
    .pin_i   (ps2_clk),
    .level_o (clkLevel)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uDatFilter (
    .clock50 (clock50),
    .rst_n   (rst_n),
    .pin_i   (ps2_dat),
    .level_o (datLevel)
  );

  ps2_xlat_rom uRom (
    .code_i (shift_q[6:0]),
    .code_o (romOut)
  );

  assign fall = clkPrev_q & ~clkLevel;

  // Deframing FSM, timeout supervision and translation of accepted bytes.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tmo_d    = '0;
    brk_d    = brk_q;
    data_d   = data_q;
    stb_d    = 1'b0;
    err_d    = 1'b0;
    accept   = 1'b0;
    if (state_q != IDLE && !fall) begin
      tmo_d = tmo_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          if (!datLevel) begin
            state_d  = DATA;
            bitCnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shift_d  = {datLevel, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = datLevel;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (datLevel && (^{shift_q, parity_q})) begin
            accept = 1'b1;
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (TRANSLATE == 0) begin
        data_d = shift_q;
        stb_d  = 1'b1;
      end else if (shift_q == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (shift_q == PS2_EXT0 || shift_q == PS2_EXT1 || shift_q[7]) begin
        data_d = shift_q;
        stb_d  = 1'b1;
      end else if (romOut == 8'h00) begin
        brk_d = 1'b0;
      end else begin
        data_d = romOut | {brk_q, 7'b0};
        stb_d  = 1'b1;
        brk_d  = 1'b0;
      end
    end
    if (state_q != IDLE && !fall && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      brk_d   = 1'b0;
      tmo_d   = '0;
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clock50 or negedge rst_n) begin
    if (!rst_n) begin
      clkPrev_q <= 1'b1;
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      brk_q     <= 1'b0;
      data_q    <= '0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clkPrev_q <= clkLevel;
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      brk_q     <= brk_d;
      data_q    <= data_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
    end
  end

  assign ps2_data     = data_q;
  assign ps2_data_clk = stb_q;
  assign ps2_err      = err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Testbench for ps2_receiver: a translating and a raw instance share the same pins.
module tb_ps2_receiver;

  localparam int HALF = 20;
  localparam int LAT  = 11;

  typedef struct {
    logic [7:0] code;
    bit         badPar;
    bit         xlValid;
    logic [7:0] xlByte;
  } vec_t;

  logic       clock50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Dat = 1'b1;
  logic [7:0] xlData, rawData;
  logic       xlStb, xlErr, rawStb, rawErr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lastFallCyc = 0;
  int xlCnt, xlErrs, rawCnt, rawErrs, protoViol;
  int xlStbCyc, xlErrCyc;
  logic [7:0] xlLast, rawLast;
  logic xlStbPrev = 1'b0, xlErrPrev = 1'b0, rawStbPrev = 1'b0, rawErrPrev = 1'b0;

  logic [7:0] xtab [0:127];
  bit mBrk = 1'b0;

  ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(5000), .TRANSLATE(1)) dutXl (
    .clock50 (clock50), .rst_n (rst_n), .ps2_clk (ps2Clk), .ps2_dat (ps2Dat),
    .ps2_data (xlData), .ps2_data_clk (xlStb), .ps2_err (xlErr)
  );

  ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(5000), .TRANSLATE(0)) dutRaw (
    .clock50 (clock50), .rst_n (rst_n), .ps2_clk (ps2Clk), .ps2_dat (ps2Dat),
    .ps2_data (rawData), .ps2_data_clk (rawStb), .ps2_err (rawErr)
  );

  always #5 clock50 = ~clock50;

  // Free-running cycle count used to time latencies.
  always @(posedge clock50) cyc <= cyc + 1;

  // Observe both instances on the falling edge and flag pulse-shape violations.
  always @(negedge clock50) begin
    if (xlStb) begin xlCnt++; xlLast = xlData; xlStbCyc = cyc; end
    if (xlErr) begin xlErrs++; xlErrCyc = cyc; end
    if (rawStb) begin rawCnt++; rawLast = rawData; end
    if (rawErr) rawErrs++;
    if ((xlStb && xlErr) || (xlStb && xlStbPrev) || (xlErr && xlErrPrev)) protoViol++;
    if ((rawStb && rawErr) || (rawStb && rawStbPrev) || (rawErr && rawErrPrev)) protoViol++;
    xlStbPrev = xlStb; xlErrPrev = xlErr; rawStbPrev = rawStb; rawErrPrev = rawErr;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock50);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearObs();
    xlCnt = 0; xlErrs = 0; rawCnt = 0; rawErrs = 0; protoViol = 0;
    xlStbCyc = 0; xlErrCyc = 0;
  endtask

  task automatic bitTask(input logic b);
    ps2Dat = b;
    waitCycles(HALF);
    ps2Clk = 1'b0;
    lastFallCyc = cyc;
    waitCycles(HALF);
    ps2Clk = 1'b1;
  endtask

  // Sends one full frame; glitchAt >= 0 inserts a 3-cycle clock-low glitch after that bit.
  task automatic applyStimulus(input logic [7:0] code, input bit bad, input int glitchAt);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad, code, 1'b0};
    for (int i = 0; i < 11; i++) begin
      bitTask(bits[i]);
      if (i == glitchAt) begin
        waitCycles(HALF);
        ps2Clk = 1'b0;
        waitCycles(3);
        ps2Clk = 1'b1;
        waitCycles(HALF);
      end
    end
    waitCycles(HALF);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] code, input bit bad,
                            input bit xlV, input logic [7:0] xlB);
    checkOutput({tag, " xl strobes"}, xlCnt, int'(xlV));
    if (xlV) begin
      checkOutput({tag, " xl byte"}, int'(xlLast), int'(xlB));
      checkOutput({tag, " strobe latency"}, xlStbCyc - lastFallCyc, LAT);
    end
    checkOutput({tag, " xl errs"}, xlErrs, int'(bad));
    checkOutput({tag, " raw strobes"}, rawCnt, int'(!bad));
    if (!bad) checkOutput({tag, " raw byte"}, int'(rawLast), int'(code));
    if (bad) checkOutput({tag, " err latency"}, xlErrCyc - lastFallCyc, LAT);
    checkOutput({tag, " raw errs"}, rawErrs, int'(bad));
    checkOutput({tag, " pulse shape"}, protoViol, 0);
  endtask

  // Reference behaviour of the translating receiver for one frame.
  task automatic modelFrame(input logic [7:0] code, input bit bad,
                            output bit xlV, output logic [7:0] xlB);
    xlV = 1'b0;
    xlB = 8'h00;
    if (bad) begin
      mBrk = 1'b0;
    end else if (code == 8'hF0) begin
      mBrk = 1'b1;
    end else if (code >= 8'h80) begin
      xlV = 1'b1;
      xlB = code;
    end else if (xtab[code[6:0]] == 8'h00) begin
      mBrk = 1'b0;
    end else begin
      xlV = 1'b1;
      xlB = xtab[code[6:0]] + (mBrk ? 8'h80 : 8'h00);
      mBrk = 1'b0;
    end
  endtask

  vec_t vecs [17];
  logic [7:0] pool [22];

  initial begin
    for (int i = 0; i < 128; i++) xtab[i] = 8'h00;
    xtab[7'h1C] = 8'h1E; xtab[7'h75] = 8'h48; xtab[7'h1B] = 8'h1F; xtab[7'h23] = 8'h20;
    xtab[7'h5A] = 8'h1C; xtab[7'h76] = 8'h01; xtab[7'h29] = 8'h39; xtab[7'h66] = 8'h0E;
    xtab[7'h16] = 8'h02; xtab[7'h45] = 8'h0B; xtab[7'h0D] = 8'h0F; xtab[7'h12] = 8'h2A;
    xtab[7'h14] = 8'h1D; xtab[7'h05] = 8'h3B;
    pool = '{8'h1C, 8'h75, 8'h1B, 8'h23, 8'h5A, 8'h76, 8'h29, 8'h66, 8'h16, 8'h45, 8'h0D,
             8'h12, 8'h14, 8'h05, 8'h02, 8'h00, 8'h7F, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'h83};

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 8'h1E};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 8'h9E};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 8'hE0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 8'hC8};
    vecs[6]  = '{8'h1C, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{8'h1C, 1'b0, 1'b1, 8'h1E};
    vecs[8]  = '{8'h02, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{8'hF0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{8'h02, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{8'h1C, 1'b0, 1'b1, 8'h1E};
    vecs[12] = '{8'hF0, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{8'hAA, 1'b0, 1'b1, 8'hAA};
    vecs[14] = '{8'h1C, 1'b0, 1'b1, 8'h9E};
    vecs[15] = '{8'hF0, 1'b1, 1'b0, 8'h00};
    vecs[16] = '{8'h1C, 1'b0, 1'b1, 8'h1E};

    clearObs();
    waitCycles(3);
    checkOutput("reset xl data", int'(xlData), 0);
    checkOutput("reset xl strobe", int'(xlStb), 0);
    checkOutput("reset xl err", int'(xlErr), 0);
    checkOutput("reset raw data", int'(rawData), 0);
    checkOutput("reset raw strobe", int'(rawStb), 0);
    checkOutput("reset raw err", int'(rawErr), 0);
    rst_n = 1'b1;
    waitCycles(20);

    for (int v = 0; v < 17; v++) begin
      clearObs();
      applyStimulus(vecs[v].code, vecs[v].badPar, -1);
      checkFrame($sformatf("vec%0d", v), vecs[v].code, vecs[v].badPar,
                 vecs[v].xlValid, vecs[v].xlByte);
    end

    // Clock pulse with data high while idle is a bad start bit.
    clearObs();
    bitTask(1'b1);
    waitCycles(HALF);
    checkOutput("bad start xl errs", xlErrs, 1);
    checkOutput("bad start raw errs", rawErrs, 1);
    checkOutput("bad start xl strobes", xlCnt, 0);
    checkOutput("bad start err latency", xlErrCyc - lastFallCyc, LAT);

    // Short clock glitch mid-frame must not shift an extra bit.
    clearObs();
    applyStimulus(8'h1C, 1'b0, 4);
    checkFrame("glitch", 8'h1C, 1'b0, 1'b1, 8'h1E);

    // Partial frame followed by a long stall triggers the timeout.
    clearObs();
    bitTask(1'b0);
    bitTask(1'b0); bitTask(1'b0); bitTask(1'b1); bitTask(1'b1);
    waitCycles(6000);
    checkOutput("timeout xl errs", xlErrs, 1);
    checkOutput("timeout raw errs", rawErrs, 1);
    checkOutput("timeout xl strobes", xlCnt, 0);
    checkOutput("timeout window", int'((xlErrCyc - lastFallCyc) >= 5009 &&
                                       (xlErrCyc - lastFallCyc) <= 5013), 1);
    clearObs();
    applyStimulus(8'h1C, 1'b0, -1);
    checkFrame("after timeout", 8'h1C, 1'b0, 1'b1, 8'h1E);

    // Reset asserted mid-frame discards the partial frame and clears outputs.
    clearObs();
    bitTask(1'b0);
    bitTask(1'b0); bitTask(1'b0); bitTask(1'b1);
    rst_n = 1'b0;
    waitCycles(3);
    checkOutput("mid reset xl data", int'(xlData), 0);
    checkOutput("mid reset raw data", int'(rawData), 0);
    checkOutput("mid reset xl strobe", int'(xlStb), 0);
    checkOutput("mid reset xl err", int'(xlErr), 0);
    rst_n = 1'b1;
    ps2Dat = 1'b1;
    waitCycles(20);
    clearObs();
    applyStimulus(8'h1C, 1'b0, -1);
    checkFrame("after reset", 8'h1C, 1'b0, 1'b1, 8'h1E);

    // Randomized frames against the reference model.
    mBrk = 1'b0;
    for (int r = 0; r < 30; r++) begin
      logic [7:0] code;
      bit bad, xlV;
      logic [7:0] xlB;
      code = pool[$urandom_range(0, 21)];
      bad = ($urandom_range(0, 9) == 0);
      modelFrame(code, bad, xlV, xlB);
      clearObs();
      applyStimulus(code, bad, -1);
      checkFrame($sformatf("rand%0d code %0h", r, code), code, bad, xlV, xlB);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
